imem_boot_ctrl: RTL

//  Owns the single-port instruction memory and shares it between a host loader and the core fetch port.

---
 rtl/imem_boot_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory owner: streams a program in from the host, then holds the core
// released and serves zero-latency fetches until the next load request.
module imem_boot_ctrl #(
  parameter int unsigned   ADDR_W    = 10,
  parameter int unsigned   DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_load_req,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  input  logic [31:0]       core_fetch_addr,
  output logic [DATA_W-1:0] core_instr,
  output logic              core_run,
  output logic              fetch_oob,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              run_q;
  logic              beat;
  logic              oob;
  logic              unused_byte_offset;

  // Byte offset within a word is irrelevant for word-aligned fetches.
  assign unused_byte_offset = ^core_fetch_addr[1:0];

  assign host_ready = (state_q == S_LOAD) && !host_load_req;
  assign beat       = host_ready && host_valid;
  assign oob        = |core_fetch_addr[31:ADDR_W+2];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (host_load_req) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          err_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (host_load_req) begin
          wr_ptr_d = '0;
          err_d    = 1'b0;
        end else if (beat) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (host_last) begin
            state_d = S_RUN;
            count_d = {1'b0, wr_ptr_q} + {{ADDR_W{1'b0}}, 1'b1};
          end else if (&wr_ptr_q) begin
            // Memory full without a last beat: keep the word, flag overflow, park in idle.
            state_d = S_IDLE;
            err_d   = 1'b1;
            count_d = {1'b1, {ADDR_W{1'b0}}};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      run_q    <= (state_d == S_RUN);
    end
  end

  always_comb begin
    mem_we     = beat;
    mem_wdata  = host_data;
    mem_addr   = '0;
    core_instr = '0;
    fetch_oob  = 1'b0;
    if (state_q == S_LOAD) begin
      mem_addr = wr_ptr_q;
    end else if (state_q == S_RUN) begin
      mem_addr   = core_fetch_addr[ADDR_W+1:2];
      fetch_oob  = oob;
      core_instr = oob ? NOP_INSTR : mem_rdata;
    end
  end

  assign core_run   = run_q;
  assign load_count = count_q;
  assign load_err   = err_q;

endmodule
